// File: rtl/csa5_seq_ctrl_pkg.sv
// Shared types and constants for the csa5 sequencer around the five-operand
// 12-bit carry-save compressor.
package csa5_pkg;

    localparam int unsigned OPW       = 12;
    localparam int unsigned RESW      = 15;
    localparam int unsigned NUM_SLOTS = 5;

    typedef enum logic [1:0] {
        COLLECT,
        COMPRESS,
        ADD,
        HOLD
    } csa5_state_t;

    typedef logic [2:0]                 slot_idx_t;
    typedef logic [OPW-1:0]             operand_t;
    typedef logic [RESW-1:0]            result_t;
    typedef operand_t [NUM_SLOTS-1:0]   slots_t;

    // Plain arithmetic sum of all slots, independent of the CSA/CPA datapath.
    function automatic result_t ref_sum(input slots_t s);
        result_t acc;
        acc = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            acc = acc + result_t'(s[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/csa5_seq_ctrl_if.sv
// Operand stream and result port of the csa5 sequencer; slave is the
// sequencer side, master is the producer/consumer side.
interface csa5_seq_ctrl_if;
    import csa5_pkg::*;

    logic      in_valid;
    logic      in_ready;
    operand_t  in_data;
    logic      in_last;
    logic      res_valid;
    logic      res_ready;
    result_t   res_data;
    slot_idx_t res_count;
    logic      err;

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_data, res_count, err
    );

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_count, err
    );

endinterface

// File: rtl/adder5x12.sv
// Five-operand 12-bit carry-save compressor: out1 + out2 equals a+b+c+d+e
// modulo 2^15 (exact, since the true sum never reaches 2^15).
module adder5x12 (
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [11:0] c,
    input  logic [11:0] d,
    input  logic [11:0] e,
    output logic [14:0] out1,
    output logic [14:0] out2
);

    logic [14:0] ea, eb, ec, ed, ee;
    logic [14:0] s1, c1, s2, c2;

    always_comb begin
        ea = {3'b000, a};
        eb = {3'b000, b};
        ec = {3'b000, c};
        ed = {3'b000, d};
        ee = {3'b000, e};
        // Three 3:2 stages reduce five vectors to two.
        s1   = ea ^ eb ^ ec;
        c1   = ((ea & eb) | (ea & ec) | (eb & ec)) << 1;
        s2   = s1 ^ ed ^ ee;
        c2   = ((s1 & ed) | (s1 & ee) | (ed & ee)) << 1;
        out1 = s2 ^ c1 ^ c2;
        out2 = ((s2 & c1) | (s2 & c2) | (c1 & c2)) << 1;
    end

endmodule

// File: rtl/csa5_seq_ctrl_cpa15.sv
// RESW-bit ripple carry-propagate adder resolving the carry-save pair.
module cpa15
    import csa5_pkg::*;
(
    input  result_t a_i,
    input  result_t b_i,
    output result_t sum_o
);

    logic carry;

    always_comb begin
        sum_o = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < RESW; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/csa5_seq_ctrl.sv
// Groups up to five operands, compresses them with adder5x12 and resolves the sum.
// Optional self-check of the datapath enabled by defining CSA5_SEQ_CHECK_EN.
module csa5_seq_ctrl
    import csa5_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    csa5_seq_ctrl_if.slave  bus
);

    csa5_state_t state_q, state_d;
    slots_t      slots_q, slots_d;
    slot_idx_t   cnt_q, cnt_d;
    result_t     csa1_q, csa2_q;
    result_t     cmp_out1, cmp_out2, cpa_sum;
    result_t     res_data_q, res_data_d;
    slot_idx_t   res_count_q, res_count_d;
    logic        accept;
    logic        close_grp;

    adder5x12 u_csa (
        .a    (slots_q[0]),
        .b    (slots_q[1]),
        .c    (slots_q[2]),
        .d    (slots_q[3]),
        .e    (slots_q[4]),
        .out1 (cmp_out1),
        .out2 (cmp_out2)
    );

    cpa15 u_cpa (
        .a_i   (csa1_q),
        .b_i   (csa2_q),
        .sum_o (cpa_sum)
    );

    always_comb begin
        state_d     = state_q;
        slots_d     = slots_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        accept      = (state_q == COLLECT) && bus.in_valid;
        close_grp   = accept && (bus.in_last || (cnt_q == slot_idx_t'(NUM_SLOTS - 1)));

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (cnt_q == slot_idx_t'(i)) begin
                            slots_d[i] = bus.in_data;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (close_grp) begin
                        state_d = COMPRESS;
                    end
                end
            end
            COMPRESS: state_d = ADD;
            ADD: begin
                res_data_d  = cpa_sum;
                res_count_d = cnt_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    slots_d = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            slots_q     <= '0;
            cnt_q       <= '0;
            csa1_q      <= '0;
            csa2_q      <= '0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            slots_q     <= slots_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            if (state_q == COMPRESS) begin
                csa1_q <= cmp_out1;
                csa2_q <= cmp_out2;
            end
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.res_valid = (state_q == HOLD);
    assign bus.res_data  = res_data_q;
    assign bus.res_count = res_count_q;

`ifdef CSA5_SEQ_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == ADD) && (ref_sum(slots_q) != cpa_sum)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_csa5_seq_ctrl.sv
// Self-checking bench for csa5_seq_ctrl: directed scenarios plus a randomized
// stream checked against a group-sum scoreboard.
module tb_csa5_seq_ctrl;
    import csa5_pkg::*;

    typedef struct {
        int sum;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic rnd_abort = 1'b0;

    always #5 clk = ~clk;

    csa5_seq_ctrl_if bus ();

    csa5_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Present one operand and hold it until accepted; returns #1 after the accepting edge.
    task automatic send_op(input logic [11:0] d, input logic last, output logic timed_out);
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        timed_out    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait for res_valid; lat counts cycles from the accept edge; returns at a negedge.
    task automatic wait_res(output int lat, output logic timed_out);
        lat       = 1;
        timed_out = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid);
        end
        checks++;
        if (bus.res_data !== 15'd0) begin
            errors++; $display("FAIL reset_res_data got=%0d exp=0", bus.res_data);
        end
        checks++;
        if (bus.res_count !== 3'd0) begin
            errors++; $display("FAIL reset_res_count got=%0d exp=0", bus.res_count);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", bus.err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_five_max();
        logic to;
        int   lat;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_op(12'hFFF, (k == 4), to);
            checks++;
            if (to) begin
                errors++; $display("FAIL five_accept_timeout op=%0d got=timeout exp=accept", k);
            end
        end
        wait_res(lat, to);
        checks++;
        if (to || lat != 3) begin
            errors++; $display("FAIL five_latency got=%0d (timeout=%b) exp=3", lat, to);
        end
        checks++;
        if (bus.res_data !== 15'd20475) begin
            errors++; $display("FAIL five_res_data got=%0d exp=20475", bus.res_data);
        end
        checks++;
        if (bus.res_count !== 3'd5) begin
            errors++; $display("FAIL five_res_count got=%0d exp=5", bus.res_count);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL five_resume got in_ready=%b res_valid=%b exp in_ready=1 res_valid=0",
                     bus.in_ready, bus.res_valid);
        end
    endtask

    task automatic test_three();
        logic to;
        int   lat;
        bus.res_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            send_op(12'(k), (k == 3), to);
        end
        wait_res(lat, to);
        checks++;
        if (to || bus.res_data !== 15'd6) begin
            errors++; $display("FAIL three_res_data got=%0d (timeout=%b) exp=6", bus.res_data, to);
        end
        checks++;
        if (bus.res_count !== 3'd3) begin
            errors++; $display("FAIL three_res_count got=%0d exp=3", bus.res_count);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_single();
        logic to;
        int   lat;
        bus.res_ready = 1'b1;
        send_op(12'h800, 1'b1, to);
        wait_res(lat, to);
        checks++;
        if (to || lat != 3 || bus.res_data !== 15'd2048) begin
            errors++;
            $display("FAIL single_res_data got=%0d lat=%0d (timeout=%b) exp=2048 lat=3",
                     bus.res_data, lat, to);
        end
        checks++;
        if (bus.res_count !== 3'd1) begin
            errors++; $display("FAIL single_res_count got=%0d exp=1", bus.res_count);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        logic to;
        int   lat;
        bus.res_ready = 1'b0;
        send_op(12'd100, 1'b0, to);
        send_op(12'd200, 1'b1, to);
        wait_res(lat, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL stall_result_timeout got=timeout exp=res_valid");
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = 12'd7;
            bus.in_last  = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.res_data !== 15'd300 || bus.res_count !== 3'd2) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got valid=%b ready=%b data=%0d count=%0d exp 1 0 300 2",
                         k, bus.res_valid, bus.in_ready, bus.res_data, bus.res_count);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_in_ready got=%b exp=1", bus.in_ready);
        end
        bus.res_ready = 1'b1;
        send_op(12'd5, 1'b1, to);
        wait_res(lat, to);
        checks++;
        if (to || bus.res_data !== 15'd5 || bus.res_count !== 3'd1) begin
            errors++;
            $display("FAIL stall_pulses_not_consumed got data=%0d count=%0d exp data=5 count=1",
                     bus.res_data, bus.res_count);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic to;
        int   lat;
        bus.res_ready = 1'b1;
        send_op(12'd500, 1'b0, to);
        send_op(12'd600, 1'b0, to);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            send_op(12'(10 * k), 1'b0, to);
        end
        wait_res(lat, to);
        checks++;
        if (to || bus.res_data !== 15'd150) begin
            errors++; $display("FAIL rstmid_res_data got=%0d (timeout=%b) exp=150", bus.res_data, to);
        end
        checks++;
        if (bus.res_count !== 3'd5) begin
            errors++; $display("FAIL rstmid_res_count got=%0d exp=5", bus.res_count);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic rnd_producer();
        logic [11:0] ops[5];
        int          len;
        int          sum;
        logic        last;
        logic        to;
        for (int g = 0; g < 1000 && !rnd_abort; g++) begin
            len = int'($urandom_range(1, 5));
            sum = 0;
            for (int k = 0; k < len; k++) begin
                ops[k] = 12'($urandom_range(0, 4095));
                sum    = sum + int'(ops[k]);
            end
            sb.push_back('{sum: sum, cnt: len});
            for (int k = 0; k < len && !rnd_abort; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_data = 12'($urandom);
                    @(posedge clk);
                    #1;
                end
                if (k == len - 1) last = (len == 5) ? 1'($urandom_range(0, 1)) : 1'b1;
                else              last = 1'b0;
                send_op(ops[k], last, to);
                if (to) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_accept_timeout group=%0d op=%0d got=timeout exp=accept", g, k);
                    rnd_abort = 1'b1;
                end
            end
        end
    endtask

    task automatic rnd_consumer();
        int      got;
        int      cyc;
        exp_t    e;
        logic    have_hold;
        result_t held_data;
        logic [2:0] held_cnt;
        got       = 0;
        cyc       = 0;
        have_hold = 1'b0;
        while (got < 1000 && cyc < 60000 && !rnd_abort) begin
            @(posedge clk);
            #1;
            bus.res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (bus.res_valid && !bus.res_ready) begin
                if (have_hold) begin
                    checks++;
                    if (bus.res_data !== held_data || bus.res_count !== held_cnt) begin
                        errors++;
                        $display("FAIL rnd_stable got data=%0d count=%0d exp data=%0d count=%0d",
                                 bus.res_data, bus.res_count, held_data, held_cnt);
                    end
                end else begin
                    have_hold = 1'b1;
                    held_data = bus.res_data;
                    held_cnt  = bus.res_count;
                end
            end else if (bus.res_valid && bus.res_ready) begin
                have_hold = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected_result got data=%0d exp=none", bus.res_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.res_data !== 15'(e.sum) || bus.res_count !== 3'(e.cnt)) begin
                        errors++;
                        $display("FAIL rnd_result n=%0d got data=%0d count=%0d exp data=%0d count=%0d",
                                 got, bus.res_data, bus.res_count, e.sum, e.cnt);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got < 1000) begin
            errors++; $display("FAIL rnd_result_count got=%0d exp=1000", got);
            rnd_abort = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_random();
        fork
            rnd_producer();
            rnd_consumer();
        join
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL rnd_err got=%b exp=0", bus.err);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_five_max();
        test_three();
        test_single();
        test_hold_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
